adc16dv160_rx: RTL

- Fabric-side receiver for the ADC16DV160 8-lane DDR sample interface.
- Each 16-bit sample crosses the interface in two halves:
  - first half, captured on the falling outclk edge: odd bits {w15,w13,w11,w9,w7,w5,w3,w1};
  - second half, captured on the rising edge: even bits {w14,w12,...,w0}.
- The block takes the per-lane IDDR outputs, trains half-word alignment against a known pattern, reassembles samples and buffers them in a FIFO with a valid/ready stream output.
- It sits between the LVDS IDDR capture and the acquisition/DMA path.

---
 rtl/adc16dv160_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/adc16dv160_rx.sv
// ADC16DV160 8-lane DDR receiver: trains half-word alignment on a test word,
// reassembles 16-bit samples and buffers them in a FIFO with a valid/ready output.
module adc16dv160_rx #(
   parameter logic [15:0] TRAIN_PATTERN = 16'hA53C,
   parameter int unsigned LOCK_COUNT    = 8,
   parameter int unsigned FIFO_DEPTH    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  d_fall,
   input  logic [7:0]  d_rise,
   input  logic        en,
   input  logic        train,
   output logic [15:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        locked,
   output logic        ovf,
   input  logic        ovf_clr,
   output logic [31:0] sample_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = 8;

   typedef enum logic {S_TRAIN = 1'b0, S_LOCKED = 1'b1} state_t;

   function automatic logic [15:0] weave(input logic [7:0] hi, input logic [7:0] lo);
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         w[2*i+1] = hi[i];
         w[2*i]   = lo[i];
      end
      return w;
   endfunction

   logic [7:0]    fall_q, fall_d, rise_q, rise_d, prev_rise_q, prev_rise_d;
   logic          en_q, en_d;
   state_t        state_q, state_d;
   logic          slip_q, slip_d;
   logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic          locked_q, locked_d;
   logic [15:0]   asm_word_q, asm_word_d;
   logic          asm_vld_q, asm_vld_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          tvalid_q, tvalid_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   sample_cnt_q, sample_cnt_d;
   logic [15:0]   mem [FIFO_DEPTH];

   logic [15:0]   cand0, cand1;
   logic          push, pop, full, accept, ovf_set;

   always_comb begin
      fall_d       = d_fall;
      rise_d       = d_rise;
      prev_rise_d  = rise_q;
      en_d         = en;
      state_d      = state_q;
      slip_d       = slip_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      cand0        = weave(fall_q, rise_q);
      cand1        = weave(prev_rise_q, fall_q);

      // Training: per-alignment run-length of matching words, saturating at LOCK_COUNT
      case (state_q)
         S_TRAIN: begin
            if (cand0 == TRAIN_PATTERN)
               cnt0_d = (cnt0_q == CW'(LOCK_COUNT)) ? cnt0_q : cnt0_q + CW'(1);
            else
               cnt0_d = '0;
            if (cand1 == TRAIN_PATTERN)
               cnt1_d = (cnt1_q == CW'(LOCK_COUNT)) ? cnt1_q : cnt1_q + CW'(1);
            else
               cnt1_d = '0;
            if (!train) begin
               if (cnt0_d == CW'(LOCK_COUNT)) begin
                  state_d = S_LOCKED;
                  slip_d  = 1'b0;
               end else if (cnt1_d == CW'(LOCK_COUNT)) begin
                  state_d = S_LOCKED;
                  slip_d  = 1'b1;
               end
            end
         end
         S_LOCKED: begin
            if (train) begin
               state_d = S_TRAIN;
               cnt0_d  = '0;
               cnt1_d  = '0;
            end
         end
         default: state_d = S_TRAIN;
      endcase
      locked_d = (state_d == S_LOCKED);

      asm_word_d = slip_q ? cand1 : cand0;
      asm_vld_d  = (state_q == S_LOCKED) && en_q;

      // FIFO: a push into a full FIFO is only accepted when a pop frees a slot
      push     = asm_vld_q && (state_q == S_LOCKED);
      pop      = tvalid_q && m_tready;
      full     = (count_q == (AW+1)'(FIFO_DEPTH));
      accept   = push && (!full || pop);
      ovf_set  = push && full && !pop;
      wr_ptr_d = wr_ptr_q + AW'(accept);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(accept) - (AW+1)'(pop);
      tvalid_d = (count_d != '0);
      ovf_d    = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
      sample_cnt_d = sample_cnt_q + 32'(accept);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fall_q       <= '0;
         rise_q       <= '0;
         prev_rise_q  <= '0;
         en_q         <= 1'b0;
         state_q      <= S_TRAIN;
         slip_q       <= 1'b0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
         locked_q     <= 1'b0;
         asm_word_q   <= '0;
         asm_vld_q    <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         tvalid_q     <= 1'b0;
         ovf_q        <= 1'b0;
         sample_cnt_q <= '0;
      end else begin
         fall_q       <= fall_d;
         rise_q       <= rise_d;
         prev_rise_q  <= prev_rise_d;
         en_q         <= en_d;
         state_q      <= state_d;
         slip_q       <= slip_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
         locked_q     <= locked_d;
         asm_word_q   <= asm_word_d;
         asm_vld_q    <= asm_vld_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         tvalid_q     <= tvalid_d;
         ovf_q        <= ovf_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   // Storage is not reset; the pointers alone define the FIFO contents
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr_q] <= asm_word_q;
   end

   assign m_tdata    = mem[rd_ptr_q];
   assign m_tvalid   = tvalid_q;
   assign locked     = locked_q;
   assign ovf        = ovf_q;
   assign sample_cnt = sample_cnt_q;

endmodule
